// File: rtl/trace_pkg.sv
// Shared types for the instruction trace capture block: FSM encoding and the record layout.
package trace_pkg;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int SEQ_W   = 16;
  localparam int DROP_W  = 16;
  localparam int POST_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trc_state_e;

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } trc_rec_t;

  localparam int REC_W = $bits(trc_rec_t);
endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO; the head entry appears on o_rdata the cycle after it is written.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_level   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clock) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/instr_trace_capture.sv
// Captures {seq, instr, pc} per fetched instruction into a FIFO, with a PC-match trigger
// that freezes capture a programmable number of records later.
module instr_trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_cap_en,
  input  logic                    i_trc_valid,
  input  logic [PC_W-1:0]         i_pc_in,
  input  logic [INSTR_W-1:0]      i_instr_in,
  input  logic                    i_trig_en,
  input  logic [PC_W-1:0]         i_trig_pc,
  input  logic [POST_W-1:0]       i_post_cnt,
  input  logic                    i_rearm,
  input  logic                    i_clear,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [PC_W-1:0]         o_out_pc,
  output logic [INSTR_W-1:0]      o_out_instr,
  output logic [SEQ_W-1:0]        o_out_seq,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [DROP_W-1:0]       o_drop_cnt,
  output logic                    o_overflow,
  output logic [1:0]              o_state,
  output logic                    o_triggered
);
  trc_state_e        r_state;
  logic [SEQ_W-1:0]  r_seq;
  logic [POST_W-1:0] r_post;
  logic [DROP_W-1:0] r_drop;
  logic              r_overflow, r_triggered;

  trc_rec_t w_wrec, w_rrec;
  logic     w_full, w_empty, w_event, w_pop, w_push, w_drop, w_match;

  assign w_event = i_trc_valid && (r_state == RUN || r_state == POST);
  assign w_pop   = !w_empty && i_out_ready;
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && !w_push;
  assign w_match = i_trig_en && (i_pc_in == i_trig_pc);
  assign w_wrec  = '{seq: r_seq, instr: i_instr_in, pc: i_pc_in};

  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_clear),
    .i_wdata (w_wrec),
    .o_rdata (w_rrec),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  assign o_out_valid = !w_empty;
  assign o_out_pc    = w_rrec.pc;
  assign o_out_instr = w_rrec.instr;
  assign o_out_seq   = w_rrec.seq;
  assign o_drop_cnt  = r_drop;
  assign o_overflow  = r_overflow;
  assign o_state     = r_state;
  assign o_triggered = r_triggered;

  // Sequence and drop bookkeeping; drops still consume a sequence number.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_seq      <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_seq      <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_event) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_post      <= '0;
      r_triggered <= 1'b0;
    end else begin
      if (!i_cap_en) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: r_state <= RUN;
          RUN: if (w_event && w_match) begin
            r_triggered <= 1'b1;
            r_post      <= i_post_cnt;
            r_state     <= (i_post_cnt == '0) ? FROZEN : POST;
          end
          POST: if (w_event) begin
            r_post <= r_post - POST_W'(1);
            if (r_post == POST_W'(1)) r_state <= FROZEN;
          end
          FROZEN: if (i_rearm) begin
            r_state     <= RUN;
            r_triggered <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
      if (i_clear) r_triggered <= 1'b0;
    end
  end
endmodule
